// File: rtl/ls_pkg.sv
// Shared types and the quadword index helper for the local-store pipeline.
// Enumerations match the encodings seen on the op/mode buses.
package ls_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_LOAD  = 2'd1,
      OP_STORE = 2'd2,
      OP_RSVD  = 2'd3
   } ls_op_t;

   typedef enum logic [1:0] {
      MODE_X = 2'd0,
      MODE_D = 2'd1,
      MODE_A = 2'd2,
      MODE_R = 2'd3
   } ls_mode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_INIT = 1'b1
   } init_state_t;

   // Drops the byte offset inside a quadword and wraps modulo the store depth.
   function automatic logic [31:0] qw_index(input logic [31:0] byte_addr, input int unsigned depth);
      return (byte_addr >> 4) & (depth - 1);
   endfunction

endpackage

// File: rtl/ls_agen.sv
// Combinational address generator: byte address per mode, then quadword index.
module ls_agen
   import ls_pkg::*;
#(
   parameter int DEPTH = 2048
) (
   input  ls_mode_t                   mode_i,
   input  logic [31:0]                a_i,
   input  logic [31:0]                b_i,
   input  logic [15:0]                imm_i,
   input  logic [31:0]                pc_i,
   output logic [$clog2(DEPTH)-1:0]   idx_o
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0] imm_d_ext;
   logic [31:0] imm_w_ext;
   logic [31:0] byte_addr;

   // D mode offsets are in quadwords, A/R mode offsets in words.
   assign imm_d_ext = {{18{imm_i[9]}}, imm_i[9:0], 4'b0000};
   assign imm_w_ext = {{14{imm_i[15]}}, imm_i, 2'b00};

   always_comb begin
      byte_addr = '0;
      case (mode_i)
         MODE_X:  byte_addr = a_i + b_i;
         MODE_D:  byte_addr = a_i + imm_d_ext;
         MODE_A:  byte_addr = imm_w_ext;
         MODE_R:  byte_addr = pc_i + imm_w_ext;
         default: byte_addr = '0;
      endcase
   end

   assign idx_o = AW'(qw_index(byte_addr, DEPTH));

endmodule

// File: rtl/ls_pipe.sv
// Local-store load/store pipeline with a fixed-latency writeback delay line,
// a cycle-stealing DMA port and a power-on memory initialiser.
//
// state   | meaning
// ST_INIT | writing the init pattern, one entry per cycle; pipeline and DMA locked out
// ST_IDLE | normal operation
module ls_pipe
   import ls_pkg::*;
#(
   parameter int DEPTH   = 2048,
   parameter int QW_BITS = 128,
   parameter int LAT     = 5
) (
   input  logic                       clock,
   input  logic                       reset,
   input  ls_op_t                     op,
   input  ls_mode_t                   mode,
   input  logic [6:0]                 dest_reg_addr,
   input  logic                       enable_reg_write,
   input  logic [QW_BITS-1:0]         src_reg_a,
   input  logic [QW_BITS-1:0]         src_reg_b,
   input  logic [QW_BITS-1:0]         store_data,
   input  logic [15:0]                imm_value,
   input  logic [31:0]                pc,
   input  logic                       branch_is_taken,
   input  logic                       dma_req,
   input  logic                       dma_we,
   input  logic [$clog2(DEPTH)-1:0]   dma_addr,
   input  logic [QW_BITS-1:0]         dma_wdata,
   output logic                       dma_ack,
   output logic [QW_BITS-1:0]         dma_rdata,
   output logic                       init_busy,
   output logic [QW_BITS-1:0]         wb_data,
   output logic [6:0]                 wb_reg_addr,
   output logic                       wb_enable_reg_write,
   output logic [LAT:0][6:0]          delayed_rt_addr,
   output logic [LAT:0]               delayed_enable_reg_write
);

   localparam int AW     = $clog2(DEPTH);
   localparam int NWORDS = QW_BITS / 32;

   logic [QW_BITS-1:0] mem_q [DEPTH];
   init_state_t        state_q, state_d;
   logic [AW-1:0]      cnt_q, cnt_d;
   logic [AW-1:0]      idx;
   logic [QW_BITS-1:0] init_word;
   logic               issue_ok, do_load, do_store;

   logic [QW_BITS-1:0] data_q [LAT];
   logic [LAT:0][6:0]  rt_q;
   logic [LAT:0]       en_q;
   logic [QW_BITS-1:0] dma_rdata_q;

   // Only the preferred (most significant) word of each source feeds the address.
   ls_agen #(.DEPTH(DEPTH)) u_agen (
      .mode_i (mode),
      .a_i    (src_reg_a[QW_BITS-1 -: 32]),
      .b_i    (src_reg_b[QW_BITS-1 -: 32]),
      .imm_i  (imm_value),
      .pc_i   (pc),
      .idx_o  (idx)
   );

   if (QW_BITS > 32) begin : g_lanes
      logic unused_lanes;
      assign unused_lanes = ^{src_reg_a[QW_BITS-33:0], src_reg_b[QW_BITS-33:0]};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
         end
         default: ;
      endcase
   end

   assign init_busy = (state_q == ST_INIT);

   always_comb begin
      init_word = '0;
      for (int j = 0; j < NWORDS; j++)
         init_word[QW_BITS-1-32*j -: 32] = 32'({cnt_q, 2'b00}) + 32'(j % 4);
   end

   assign issue_ok = !init_busy && !branch_is_taken;
   assign do_load  = issue_ok && (op == OP_LOAD);
   assign do_store = issue_ok && (op == OP_STORE);
   assign dma_ack  = dma_req && !init_busy && !(do_load || do_store);

   // The three writers are mutually exclusive by construction of dma_ack/issue_ok.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (init_busy)              mem_q[cnt_q]    <= init_word;
         else if (do_store)          mem_q[idx]      <= store_data;
         else if (dma_ack && dma_we) mem_q[dma_addr] <= dma_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < LAT; k++) data_q[k] <= '0;
         rt_q        <= '0;
         en_q        <= '0;
         dma_rdata_q <= '0;
      end else begin
         data_q[0] <= do_load ? mem_q[idx] : '0;
         for (int k = 1; k < LAT; k++) data_q[k] <= data_q[k-1];
         rt_q <= {rt_q[LAT-1:0], (do_load ? dest_reg_addr : 7'd0)};
         en_q <= {en_q[LAT-1:0], (do_load && enable_reg_write)};
         if (dma_ack && !dma_we) dma_rdata_q <= mem_q[dma_addr];
      end
   end

   assign wb_data                  = data_q[LAT-1];
   assign wb_reg_addr              = rt_q[LAT-1];
   assign wb_enable_reg_write      = en_q[LAT-1];
   assign delayed_rt_addr          = rt_q;
   assign delayed_enable_reg_write = en_q;
   assign dma_rdata                = dma_rdata_q;

endmodule

// File: tb/tb_ls_pipe.sv
// Randomised and directed bench for ls_pipe against a queue-based reference model.
module tb_ls_pipe;
   import ls_pkg::*;

   localparam int DEPTH = 2048;
   localparam int QW    = 128;
   localparam int LAT   = 5;
   localparam int AW    = 11;

   logic              clock = 1'b0;
   logic              reset;
   ls_op_t            op;
   ls_mode_t          mode;
   logic [6:0]        dest_reg_addr;
   logic              enable_reg_write;
   logic [QW-1:0]     src_reg_a, src_reg_b, store_data;
   logic [15:0]       imm_value;
   logic [31:0]       pc;
   logic              branch_is_taken;
   logic              dma_req, dma_we;
   logic [AW-1:0]     dma_addr;
   logic [QW-1:0]     dma_wdata;
   logic              dma_ack;
   logic [QW-1:0]     dma_rdata;
   logic              init_busy;
   logic [QW-1:0]     wb_data;
   logic [6:0]        wb_reg_addr;
   logic              wb_enable_reg_write;
   logic [LAT:0][6:0] delayed_rt_addr;
   logic [LAT:0]      delayed_enable_reg_write;

   always #5 clock = ~clock;

   ls_pipe #(.DEPTH(DEPTH), .QW_BITS(QW), .LAT(LAT)) dut (
      .clock(clock), .reset(reset), .op(op), .mode(mode),
      .dest_reg_addr(dest_reg_addr), .enable_reg_write(enable_reg_write),
      .src_reg_a(src_reg_a), .src_reg_b(src_reg_b), .store_data(store_data),
      .imm_value(imm_value), .pc(pc), .branch_is_taken(branch_is_taken),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata), .init_busy(init_busy),
      .wb_data(wb_data), .wb_reg_addr(wb_reg_addr), .wb_enable_reg_write(wb_enable_reg_write),
      .delayed_rt_addr(delayed_rt_addr), .delayed_enable_reg_write(delayed_enable_reg_write)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   typedef struct packed {
      logic [127:0] data;
      logic [6:0]   rt;
      logic         en;
   } ent_t;

   logic [127:0] m_mem [DEPTH];
   ent_t         m_pipe [$];     // m_pipe[k] is what stage k must hold
   int           busy_left = 0;  // init entries still to be written
   logic [127:0] m_rdata = '0;

   function automatic logic [127:0] pattern(input int i);
      return {32'(4*i), 32'(4*i+1), 32'(4*i+2), 32'(4*i+3)};
   endfunction

   function automatic int m_index(input ls_mode_t md, input logic [31:0] a, input logic [31:0] b,
                                  input logic [15:0] imm, input logic [31:0] p);
      longint s;
      case (md)
         MODE_X:  s = longint'(a) + longint'(b);
         MODE_D:  s = longint'(a) + 16 * longint'($signed(imm[9:0]));
         MODE_A:  s = 4 * longint'($signed(imm));
         default: s = longint'(p) + 4 * longint'($signed(imm));
      endcase
      s = s & 64'hFFFF_FFFF;
      return int'((s / 16) % DEPTH);
   endfunction

   task automatic set_nop();
      op = OP_NOP; mode = MODE_X; dest_reg_addr = '0; enable_reg_write = 1'b0;
      src_reg_a = '0; src_reg_b = '0; store_data = '0; imm_value = '0; pc = '0;
      branch_is_taken = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
   endtask

   task automatic set_op(input ls_op_t o, input ls_mode_t md, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm, input logic [31:0] p, input logic [6:0] rt,
                         input logic en, input logic [127:0] sd);
      op = o; mode = md; imm_value = imm; pc = p; dest_reg_addr = rt; enable_reg_write = en;
      src_reg_a = {a, $urandom, $urandom, $urandom};
      src_reg_b = {b, $urandom, $urandom, $urandom};
      store_data = sd;
   endtask

   // One clock: check dma_ack before the edge, advance the model, check outputs after it.
   task automatic step();
      logic   busy, acc, ack_exp;
      ls_op_t eop;
      ent_t   e;
      int     idx;
      busy = (busy_left > 0);
      #2;
      eop     = (busy || branch_is_taken) ? OP_NOP : op;
      acc     = (eop == OP_LOAD) || (eop == OP_STORE);
      ack_exp = dma_req && !busy && !acc;
      check_eq("dma_ack", dma_ack, ack_exp);
      idx = m_index(mode, src_reg_a[127:96], src_reg_b[127:96], imm_value, pc);
      @(posedge clock);
      if (reset) begin
         busy_left = DEPTH;
         m_rdata   = '0;
         m_pipe    = {};
         for (int k = 0; k <= LAT; k++) m_pipe.push_back('0);
      end else begin
         e = '0;
         if (busy) begin
            m_mem[DEPTH-busy_left] = pattern(DEPTH - busy_left);
            busy_left--;
         end
         if (eop == OP_LOAD) e = '{data: m_mem[idx], rt: dest_reg_addr, en: enable_reg_write};
         if (eop == OP_STORE) m_mem[idx] = store_data;
         if (ack_exp && !dma_we) m_rdata = m_mem[dma_addr];
         if (ack_exp && dma_we) m_mem[dma_addr] = dma_wdata;
         m_pipe.push_front(e);
         void'(m_pipe.pop_back());
      end
      #1;
      check_eq("init_busy", init_busy, busy_left > 0);
      check_eq("wb_data", wb_data, m_pipe[LAT-1].data);
      check_eq("wb_reg_addr", wb_reg_addr, m_pipe[LAT-1].rt);
      check_eq("wb_en", wb_enable_reg_write, m_pipe[LAT-1].en);
      check_eq("dma_rdata", dma_rdata, m_rdata);
      for (int k = 0; k <= LAT; k++) begin
         check_eq($sformatf("dly_rt%0d", k), delayed_rt_addr[k], m_pipe[k].rt);
         check_eq($sformatf("dly_en%0d", k), delayed_enable_reg_write[k], m_pipe[k].en);
      end
   endtask

   task automatic randomize_inputs();
      logic [15:0] imm;
      imm = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
      set_op(ls_op_t'($urandom_range(0, 3)), ls_mode_t'($urandom_range(0, 3)),
             32'($urandom_range(0, 511)), 32'($urandom_range(0, 511)), imm,
             32'($urandom_range(0, 1023)), 7'($urandom), 1'($urandom),
             {$urandom, $urandom, $urandom, $urandom});
      branch_is_taken = ($urandom_range(0, 7) == 0);
      dma_req   = ($urandom_range(0, 2) == 0);
      dma_we    = 1'($urandom);
      dma_addr  = AW'($urandom_range(0, 63));
      dma_wdata = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic nops(input int n);
      set_nop();
      for (int i = 0; i < n; i++) step();
   endtask

   // Steps with random traffic until init_busy drops; returns the number of busy cycles.
   task automatic wait_init(output int cycles);
      cycles = 0;
      for (int i = 0; i < 3 * DEPTH && init_busy; i++) begin
         randomize_inputs();
         step();
         cycles++;
      end
      set_nop();
   endtask

   initial begin
      int cyc;
      set_nop();
      for (int k = 0; k <= LAT; k++) m_pipe.push_back('0);

      reset = 1'b1;
      step();
      step();
      check_eq("rst_wb_data", wb_data, '0);
      check_eq("rst_init_busy", init_busy, 1'b1);
      reset = 1'b0;
      wait_init(cyc);
      check_eq("init_len", cyc, DEPTH);

      set_op(OP_LOAD, MODE_A, 32'h0, 32'h0, 16'd4, 32'h0, 7'h09, 1'b1, '0);
      step();
      nops(LAT - 1);
      check_eq("a_mode_load", wb_data, 128'h00000004_00000005_00000006_00000007);
      check_eq("a_mode_rt", wb_reg_addr, 7'h09);

      set_op(OP_STORE, MODE_X, 32'h20, 32'h10, 16'h0, 32'h0, 7'h00, 1'b0, {16{8'hAA}});
      step();
      set_op(OP_LOAD, MODE_D, 32'h0, 32'h0, 16'd3, 32'h0, 7'h15, 1'b1, '0);
      step();
      nops(LAT - 1);
      check_eq("st_ld_data", wb_data, {16{8'hAA}});
      check_eq("st_ld_rt", wb_reg_addr, 7'h15);
      check_eq("st_ld_en", wb_enable_reg_write, 1'b1);

      set_op(OP_LOAD, MODE_A, 32'h0, 32'h0, 16'd12, 32'h0, 7'h22, 1'b1, '0);
      branch_is_taken = 1'b1;
      step();
      check_eq("flush_stage0_en", delayed_enable_reg_write[0], 1'b0);
      check_eq("flush_stage0_rt", delayed_rt_addr[0], 7'h00);
      set_op(OP_STORE, MODE_A, 32'h0, 32'h0, 16'd12, 32'h0, 7'h00, 1'b0, {16{8'h55}});
      branch_is_taken = 1'b1;
      step();
      nops(LAT - 2);
      check_eq("flush_wb_en", wb_enable_reg_write, 1'b0);
      set_op(OP_LOAD, MODE_A, 32'h0, 32'h0, 16'd12, 32'h0, 7'h23, 1'b1, '0);
      step();
      nops(LAT - 1);
      check_eq("flush_mem_kept", wb_data, {16{8'hAA}});

      for (int i = 0; i < 4; i++) begin
         set_op(OP_LOAD, MODE_A, 32'h0, 32'h0, 16'(4 * i), 32'h0, 7'h30, 1'b1, '0);
         dma_req = 1'b1; dma_we = 1'b0; dma_addr = AW'(5);
         step();
      end
      set_nop();
      dma_req = 1'b1; dma_addr = AW'(5);
      step();
      set_nop();
      step();
      check_eq("dma_read", dma_rdata, 128'h00000014_00000015_00000016_00000017);
      nops(3);
      check_eq("dma_hold", dma_rdata, 128'h00000014_00000015_00000016_00000017);

      set_op(OP_LOAD, MODE_R, 32'h0, 32'h0, 16'hFFFF, 32'h10, 7'h31, 1'b1, '0);
      step();
      nops(LAT - 1);
      check_eq("r_mode_load", wb_data, 128'h00000000_00000001_00000002_00000003);
      set_op(OP_LOAD, MODE_X, 32'h8000, 32'h0, 16'h0, 32'h0, 7'h32, 1'b1, '0);
      step();
      nops(LAT - 1);
      check_eq("wrap_load", wb_data, 128'h00000000_00000001_00000002_00000003);

      for (int i = 0; i < 1500; i++) begin
         randomize_inputs();
         step();
      end

      set_nop();
      reset = 1'b1;
      step();
      reset = 1'b0;
      nops(1000);
      reset = 1'b1;
      step();
      reset = 1'b0;
      wait_init(cyc);
      check_eq("reinit_len", cyc, DEPTH);
      set_op(OP_LOAD, MODE_A, 32'h0, 32'h0, 16'd12, 32'h0, 7'h40, 1'b1, '0);
      step();
      set_op(OP_LOAD, MODE_D, 32'd24000, 32'h0, 16'h0, 32'h0, 7'h41, 1'b1, '0);
      step();
      nops(LAT - 2);
      check_eq("reinit_low", wb_data, 128'h0000000C_0000000D_0000000E_0000000F);
      nops(1);
      check_eq("reinit_high", wb_data, pattern(1500));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ls_pipe.md
LS_PIPE -- requirements
Module: ls_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, giving quadword entries in local store (power of 2, 64..65536).
REQ-002 SHALL have parameter QW_BITS, default 128, giving quadword width in bits (multiple of 32).
REQ-003 SHALL have parameter LAT, default 5, giving load-to-writeback latency in cycles (2..8).
REQ-004 SHALL have ports clock (in, 1) and reset (in, 1); one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports op (in, 2, ls_op_t) and mode (in, 2, ls_mode_t), giving the operation and the address mode.
REQ-006 SHALL have port dest_reg_addr (in, 7) and port enable_reg_write (in, 1).
REQ-007 SHALL have ports src_reg_a and src_reg_b (in, QW_BITS each); the address uses only the preferred word, bits [0:31].
REQ-008 SHALL have port store_data (in, QW_BITS), port imm_value (in, 16) and port pc (in, 32).
REQ-009 SHALL have port branch_is_taken (in, 1).
REQ-010 SHALL have DMA input ports dma_req (1), dma_we (1), dma_addr (log2 DEPTH, quadword index) and dma_wdata (QW_BITS).
REQ-011 SHALL have DMA output ports dma_ack (1) and dma_rdata (QW_BITS).
REQ-012 SHALL have output port init_busy (1).
REQ-013 SHALL have output ports wb_data (QW_BITS), wb_reg_addr (7) and wb_enable_reg_write (1).
REQ-014 SHALL have output ports delayed_rt_addr ([LAT+1] x 7) and delayed_enable_reg_write ([LAT+1] x 1), exposed for forwarding.

Function
REQ-015 Byte address SHALL be: X mode = a+b; D mode = a+(sext(imm[9:0])<<4); A mode = sext(imm)<<2; R mode = pc+(sext(imm)<<2); all 32-bit, wrapping.
REQ-016 Quadword index SHALL be address bits [log2(DEPTH)+3:4]; the low 4 bits are ignored; higher bits wrap modulo DEPTH.
REQ-017 Stage 0 SHALL capture each issue edge; stages 1..LAT SHALL shift by one stage per clock; wb_* SHALL equal stage LAT-1, giving a load issued at edge E on wb_* after edge E+LAT-1.
REQ-018 A LOAD SHALL put mem[index] into stage-0 data, dest_reg_addr into stage-0 address and enable_reg_write into stage-0 enable.
REQ-019 A STORE SHALL write store_data to mem[index] at the issue edge; its stage-0 entry SHALL be all zero with enable 0.
REQ-020 A NOP, a reserved op, or any op while branch_is_taken=1 SHALL produce an all-zero stage-0 entry and no memory write.
REQ-021 A LOAD on the cycle after a STORE to the same index SHALL return the new data.
REQ-022 dma_ack SHALL be combinational and high when dma_req=1, init_busy=0, and the pipeline slot does no memory access (a NOP, a reserved op, or a flushed op).
REQ-023 When dma_ack=1, the DMA access SHALL occur at that edge; for a read, dma_rdata SHALL be valid the next cycle and held until the next acked read.
REQ-024 The pipeline SHALL always have priority; a blocked DMA request SHALL hold its request until acked, with no timeout.
REQ-025 The init FSM SHALL have two states, IDLE and INIT; reset SHALL enter INIT with counter 0.
REQ-026 In INIT, the FSM SHALL write mem[i] = {4i, 4i+1, 4i+2, 4i+3} as 32-bit words (repeated QW_BITS/128 times) at one entry per cycle; after i = DEPTH-1 it SHALL go to IDLE.
REQ-027 init_busy SHALL be 1 in INIT; while it is 1, pipeline ops SHALL be treated as NOP and dma_ack SHALL be 0.
REQ-028 A reset during INIT SHALL restart INIT at counter 0.

Reset
REQ-029 Reset SHALL clear all delay stages, wb_*, delayed_* and dma_rdata to 0.
REQ-030 Reset SHALL drive init_busy=1 in the cycle after the reset edge; memory contents are defined only after INIT completes.

Structure
REQ-031 Package ls_pkg SHALL hold ls_op_t (NOP=0, LOAD=1, STORE=2, reserved=3), ls_mode_t (X=0, D=1, A=2, R=3) and the function computing the quadword index.
REQ-032 Sub-module ls_agen SHALL be the combinational address generator (REQ-015/016); the memory array, delay line and FSM SHALL stay in ls_pipe.

Verification
REQ-033 Reset, then wait DEPTH cycles -> init_busy drops after exactly DEPTH cycles; LOAD A-mode imm=4 (index 1) -> wb_data={4,5,6,7} after LAT-1 edges.
REQ-034 STORE X-mode a=0x20, b=0x10 (index 3) data=0xAA..; next cycle LOAD D-mode a=0, imm=3 -> wb_data=0xAA.., wb_reg_addr as issued.
REQ-035 LOAD with branch_is_taken=1 -> stage 0 all zero, wb_enable_reg_write=0 at the expected slot, memory unchanged.
REQ-036 dma_req read at index 5 while LOADs issue back-to-back -> dma_ack=0 throughout; first NOP -> dma_ack=1, next cycle dma_rdata={20,21,22,23}.
REQ-037 R-mode pc=0x10, imm=0xFFFF -> byte address 0xC, index 0; byte address 0x8000 with DEPTH=2048 -> index 0 (wrap).
REQ-038 Assert reset at init counter 1000 -> init restarts at 0 and init_busy stays high for a full DEPTH cycles.
